// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle between the MIPS pipeline and the branch predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic              ready;
  logic [31:0]       mispredict_count;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, ready, mispredict_count
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target, ready, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: zero-latency lookup for IF,
// one update port from the resolving stage, and a post-reset sweep that clears the tables.
module branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int ADDR_W     = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);
  localparam int                    TAG_W    = ADDR_W - INDEX_BITS - 2;
  localparam logic [CTR_BITS-1:0]   CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]   CTR_WT   = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CTR_ONE  = CTR_BITS'(1);
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [INDEX_BITS-1:0] init_idx;
  logic [INDEX_BITS-1:0] init_idx_next;
  logic                  ready_int;
  logic [31:0]           miss_cnt;

  logic                  valid_mem  [ENTRIES];
  logic [TAG_W-1:0]      tag_mem    [ENTRIES];
  logic [ADDR_W-1:0]     target_mem [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_mem    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [ADDR_W-1:0]     lk_fall;
  logic                  lk_hit;
  logic                  lk_taken;
  logic [ADDR_W-1:0]     lk_target;

  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_fire;
  logic                  up_hit;
  logic [CTR_BITS-1:0]   ctr_cur;
  logic [CTR_BITS-1:0]   ctr_inc;
  logic [CTR_BITS-1:0]   ctr_dec;

  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  logic                  wr_valid;
  logic [TAG_W-1:0]      wr_tag;
  logic [ADDR_W-1:0]     wr_target;
  logic [CTR_BITS-1:0]   wr_ctr;

  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_next;
      init_idx <= init_idx_next;
    end
  end

  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    case (state)
      INIT: begin
        if (init_idx == LAST_IDX) begin
          state_next = RUN;
        end else begin
          init_idx_next = init_idx + INDEX_BITS'(1);
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next    = INIT;
        init_idx_next = '0;
      end
    endcase
  end

  assign ready_int = (state == RUN);

  // Lookup reads the tables as they stand before this edge's update; no bypass.
  assign lk_idx  = bus.lookup_pc[INDEX_BITS+1:2];
  assign lk_tag  = bus.lookup_pc[ADDR_W-1:INDEX_BITS+2];
  assign lk_fall = bus.lookup_pc + ADDR_W'(4);

  always_comb begin
    lk_hit    = 1'b0;
    lk_taken  = 1'b0;
    lk_target = lk_fall;
    if (ready_int && valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag)) begin
      lk_hit = 1'b1;
      if (ctr_mem[lk_idx][CTR_BITS-1]) begin
        lk_taken  = 1'b1;
        lk_target = target_mem[lk_idx];
      end
    end
  end

  assign up_idx  = bus.upd_pc[INDEX_BITS+1:2];
  assign up_tag  = bus.upd_pc[ADDR_W-1:INDEX_BITS+2];
  assign up_fire = ready_int && bus.upd_valid;
  assign up_hit  = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
  assign ctr_cur = ctr_mem[up_idx];
  assign ctr_inc = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_ONE;
  assign ctr_dec = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_ONE;

  // Single write port shared by the init sweep and the resolve-stage update.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = up_idx;
    wr_valid  = valid_mem[up_idx];
    wr_tag    = tag_mem[up_idx];
    wr_target = target_mem[up_idx];
    wr_ctr    = ctr_cur;
    if (state == INIT) begin
      wr_en     = 1'b1;
      wr_idx    = init_idx;
      wr_valid  = 1'b0;
      wr_tag    = '0;
      wr_target = '0;
      wr_ctr    = CTR_WNT;
    end else if (up_fire) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          wr_ctr    = ctr_inc;
          wr_target = bus.upd_target;
        end else begin
          wr_ctr = ctr_dec;
        end
      end else if (bus.upd_taken) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_target = bus.upd_target;
        wr_ctr    = CTR_WT;
      end
    end
  end

  // Table contents survive rst; only the sweep that follows it clears them.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      valid_mem[wr_idx]  <= wr_valid;
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
      ctr_mem[wr_idx]    <= wr_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (up_fire && bus.upd_mispredict && (miss_cnt != 32'hFFFF_FFFF)) begin
      miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.pred_hit         = lk_hit;
  assign bus.pred_taken       = lk_taken;
  assign bus.pred_target      = lk_target;
  assign bus.ready            = ready_int;
  assign bus.mispredict_count = miss_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed walk through init, training, aliasing, hazards and
// statistics, then random traffic, all compared against an array-based behavioural model.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(ADDR_W)) bus ();

  branch_predictor #(
    .ENTRIES(ENTRIES),
    .INDEX_BITS(4),
    .CTR_BITS(2),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Behavioural model: per-slot records with the counter kept as a plain 0..3 integer.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_ready = 1'b0;
  int          m_sweep = 0;
  int unsigned m_miss  = 0;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic um);
    bus.lookup_pc      = lpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utgt;
    bus.upd_mispredict = um;
    #1;
  endtask

  task automatic modelEdge();
    int unsigned i;
    int unsigned t;
    if (rst) begin
      m_ready = 1'b0;
      m_sweep = 0;
      m_miss  = 0;
    end else if (!m_ready) begin
      m_sweep++;
      if (m_sweep == ENTRIES) begin
        m_ready = 1'b1;
        foreach (m_valid[k]) m_valid[k] = 1'b0;
      end
    end else if (bus.upd_valid) begin
      if (bus.upd_mispredict && m_miss != 32'hFFFF_FFFF) m_miss++;
      i = (bus.upd_pc / 4) % ENTRIES;
      t = bus.upd_pc / (4 * ENTRIES);
      if (m_valid[i] && m_tag[i] == t) begin
        if (bus.upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = bus.upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (bus.upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = t;
        m_tgt[i]   = bus.upd_target;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkLookup(input string name);
    int unsigned i;
    int unsigned t;
    bit          e_hit;
    bit          e_taken;
    int unsigned e_tgt;
    i       = (bus.lookup_pc / 4) % ENTRIES;
    t       = bus.lookup_pc / (4 * ENTRIES);
    e_hit   = m_ready && m_valid[i] && m_tag[i] == t;
    e_taken = e_hit && m_ctr[i] >= 2;
    e_tgt   = e_taken ? m_tgt[i] : bus.lookup_pc + 32'd4;
    checkOutput({name, "_ready"}, 32'(bus.ready), 32'(m_ready));
    checkOutput({name, "_hit"}, 32'(bus.pred_hit), 32'(e_hit));
    checkOutput({name, "_taken"}, 32'(bus.pred_taken), 32'(e_taken));
    checkOutput({name, "_target"}, bus.pred_target, e_tgt);
  endtask

  task automatic checkCount(input string name);
    checkOutput(name, bus.mispredict_count, m_miss);
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_0000;
    return pc;
  endfunction

  initial begin
    int edges;

    // Reset held for two edges, then the sweep with an update that must be ignored.
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    step();
    step();
    checkLookup("reset");
    checkOutput("reset_count", bus.mispredict_count, 32'h0);
    rst = 1'b0;
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    edges = 0;
    while (!bus.ready && edges < 40) begin
      step();
      edges++;
    end
    checkOutput("init_edges", 32'(edges), 32'd16);
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkLookup("post_init");
    checkOutput("post_init_target", bus.pred_target, 32'h44);
    checkCount("post_init_count");

    // Training sequence on pc 0x40 including saturation at the top.
    applyStimulus(32'h100, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    step();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkLookup("train_alloc");
    checkOutput("train_alloc_target", bus.pred_target, 32'h80);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    step();
    checkLookup("train_nt");
    checkOutput("train_nt_target", bus.pred_target, 32'h44);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
      step();
      checkLookup("train_t");
    end
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    step();
    checkLookup("train_sat");
    checkOutput("train_sat_taken", 32'(bus.pred_taken), 32'd1);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    step();
    checkOutput("train_ctr01_taken", 32'(bus.pred_taken), 32'd0);

    // Same-cycle lookup and update: lookup sees the old counter.
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    checkLookup("hazard_same");
    checkOutput("hazard_same_taken", 32'(bus.pred_taken), 32'd0);
    step();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkLookup("hazard_next");
    checkOutput("hazard_next_taken", 32'(bus.pred_taken), 32'd1);

    // Aliasing at index 0: not-taken miss leaves the entry, taken miss replaces it.
    applyStimulus(32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    step();
    checkLookup("alias_keep");
    checkOutput("alias_keep_hit", 32'(bus.pred_hit), 32'd1);
    applyStimulus(32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0);
    step();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkLookup("alias_old");
    checkOutput("alias_old_hit", 32'(bus.pred_hit), 32'd0);
    applyStimulus(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkLookup("alias_new");
    checkOutput("alias_new_target", bus.pred_target, 32'h200);

    // Mispredict statistics, qualification by upd_valid, and saturation.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(32'h0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h0, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b1);
      step();
    end
    checkCount("stats_count");
    checkOutput("stats_count_five", bus.mispredict_count, 32'd5);
    force dut.miss_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt;
    m_miss = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(32'h0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
      step();
    end
    checkCount("stats_sat");
    checkOutput("stats_sat_value", bus.mispredict_count, 32'hFFFF_FFFF);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(randPc(), 1'($urandom_range(0, 1)), randPc(), 1'($urandom_range(0, 1)),
                    $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      checkLookup("rand");
      step();
      checkCount("rand_count");
    end

    // Reset while running, and again mid-sweep at init_idx 7.
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    step();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("pre_rst_hit", 32'(bus.pred_hit), 32'd1);
    rst = 1'b1;
    step();
    checkLookup("run_rst");
    checkOutput("run_rst_ready", 32'(bus.ready), 32'd0);
    checkCount("run_rst_count");
    rst = 1'b0;
    for (int k = 0; k < 7; k++) step();
    checkOutput("mid_sweep_ready", 32'(bus.ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    edges = 0;
    while (!bus.ready && edges < 40) begin
      step();
      edges++;
    end
    checkOutput("resweep_edges", 32'(edges), 32'd16);
    checkLookup("resweep");
    checkOutput("resweep_hit", 32'(bus.pred_hit), 32'd0);
    checkOutput("resweep_count", bus.mispredict_count, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the five-stage MIPS pipeline. It replaces static not-taken fetch with a direct-mapped branch target buffer (BTB) and per-entry saturating counters.
- IF stage looks up the current PC combinationally and gets a predicted next PC.
- The branch-resolving stage writes back the actual outcome and target.
- A post-reset init sweep clears the tables one entry per cycle. A mispredict statistics counter is exposed for debug.

Parameters:
- ENTRIES, 16, number of BTB/counter entries; must equal 2**INDEX_BITS.
- INDEX_BITS, 4, index width; index = pc[INDEX_BITS+1:2].
- CTR_BITS, 2, saturating counter width (>=1).
- ADDR_W, 32, PC/target width; tag = pc[ADDR_W-1:INDEX_BITS+2].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_pc  in  ADDR_W  PC of instruction being fetched.
- pred_hit  out  1  valid entry with matching tag for lookup_pc.
- pred_taken  out  1  predict taken.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  resolved branch/jump update strobe, one per resolved control instruction.
- upd_pc  in  ADDR_W  PC of resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual taken target (BTA / jump address).
- upd_mispredict  in  1  pipeline flushed for this instruction; qualified by upd_valid.
- ready  out  1  init sweep done; predictor active.
- mispredict_count  out  32  saturating count of mispredicts.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst sampled high at a clock edge takes effect at that edge, with priority over everything else.
- Reset values: state=INIT, init_idx=0, ready=0, mispredict_count=0. Table contents are not touched by rst itself; the sweep clears them.
- FSM state INIT:
  - Each edge with rst low clears entry init_idx: valid=0, counter=WNT=2**(CTR_BITS-1)-1.
  - At that edge, if init_idx==ENTRIES-1, state becomes RUN; otherwise init_idx increments.
  - ready goes to 1 exactly ENTRIES edges after rst deasserts.
  - upd_* is ignored and mispredict_count does not increment.
- FSM state RUN:
  - ready=1; normal operation; stays in RUN until rst.
  - rst in RUN, or in mid-INIT, restarts INIT from index 0.
- Lookup (combinational, zero latency):
  - pred_hit = ready & valid[idx] & tag[idx]==lookup tag.
  - pred_taken = pred_hit & counter[idx][CTR_BITS-1].
  - pred_target = pred_taken ? target[idx] : lookup_pc+4 (mod 2**ADDR_W).
  - When ready=0, all outputs are the not-taken fall-through: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- Update (on edge, RUN only, upd_valid=1); i = upd_pc index, t = upd_pc tag:
  - Tag hit and upd_taken: counter saturating +1 (max 2**CTR_BITS-1); target <= upd_target.
  - Tag hit and not taken: counter saturating -1 (min 0); target unchanged.
  - Tag miss (or invalid entry) and upd_taken: allocate; valid=1, tag=t, target=upd_target, counter=WT=2**(CTR_BITS-1).
  - Tag miss and not taken: no change.
- Same cycle, same index for lookup and update: lookup returns pre-update contents (no bypass). The new value is visible the next cycle.
- mispredict_count: +1 on each RUN edge with upd_valid & upd_mispredict; saturates at 32'hFFFFFFFF.
- Only one update port; no write conflicts. The index ignores pc[1:0].

Test Plan:
- Init timing: assert rst 2 cycles, release. Required: ready=0 for exactly 16 edges, then 1. During init, an update of pc=0x40 taken to 0x80 is ignored: after ready, lookup 0x40 gives pred_hit=0, pred_target=0x44.
- Training: after ready, update pc=0x40 taken target 0x80. Next cycle lookup 0x40 gives hit=1, taken=1 (counter 10), target=0x80. One not-taken update gives counter 01, pred_taken=0, target=0x44. Two more taken updates give 11; a third taken stays 11 (saturation).
- Alias replacement: pc 0x40 trained taken to 0x80. Update pc 0x80 (same index 0) not taken: no change, lookup 0x40 still hits. Update pc 0x80 taken target 0x200: lookup 0x40 gives hit=0, lookup 0x80 gives taken/0x200.
- Same-cycle hazard: lookup 0x40 while updating 0x40 from counter 01 to 10. Same-cycle lookup gives taken=0; next cycle gives taken=1.
- Counter stats: 5 updates with mispredict=1 plus 3 with mispredict=1 but upd_valid=0 give mispredict_count=5. Preload 32'hFFFFFFFE via force and apply 2 mispredicts: count stays 32'hFFFFFFFF.
- Mid-operation reset: pulse rst at init_idx=7, and again in RUN after training. Required: ready drops next edge, returns 16 edges later. Trained entries read hit=0; mispredict_count=0.
